// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multicycle control FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP)
// with a ready/done watchdog. Define M_MODULE_EN to sequence the multi-cycle M-extension unit.
module multicycle_control #(
  parameter  int WAIT_LIMIT = 15,
  localparam int WAIT_W     = $clog2(WAIT_LIMIT + 1)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] inst_opcode,
  input  logic       inst_bit_30,
  input  logic       inst_bit_25,
  input  logic       inst_mem_ready,
  input  logic       data_mem_ready,
  input  logic       alu_done,
  output logic       inst_mem_read_enable,
  output logic       ir_write_enable,
  output logic       pc_write_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [2:0] alu_op_type,
  output logic       jal_enable,
  output logic       jalr_enable,
  output logic       branch_enable,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic       CTL_ALU_A_RS1 = 1'b0;
  localparam logic       CTL_ALU_A_PC  = 1'b1;
  localparam logic       CTL_ALU_B_RS2 = 1'b0;
  localparam logic       CTL_ALU_B_IMM = 1'b1;

  localparam logic [2:0] CTL_ALU_ZERO      = 3'd0;
  localparam logic [2:0] CTL_ALU_ADD       = 3'd1;
  localparam logic [2:0] CTL_ALU_DEFAULT   = 3'd2;
  localparam logic [2:0] CTL_ALU_SECONDARY = 3'd3;
  localparam logic [2:0] CTL_ALU_BRANCH    = 3'd4;

  localparam logic [2:0] CTL_WRITEBACK_ALU  = 3'd0;
  localparam logic [2:0] CTL_WRITEBACK_DATA = 3'd1;
  localparam logic [2:0] CTL_WRITEBACK_PC4  = 3'd2;
  localparam logic [2:0] CTL_WRITEBACK_IMM  = 3'd3;

  localparam logic [1:0] CAUSE_NONE        = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL     = 2'd1;
  localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'd2;

`ifdef M_MODULE_EN
  localparam logic [2:0] CTL_ALU_M_EXTENSION = 3'd5;
  localparam logic [1:0] CAUSE_M_TIMEOUT     = 2'd3;
  logic w_is_mul;
`else
  logic w_unused;
  assign w_unused = inst_bit_25 ^ alu_done;
`endif

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  state_t            r_state, w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_trap_cause, w_next_cause;
  logic              w_waiting, w_expire;
  logic              w_legal, w_alu_a, w_alu_b, w_rf_we, w_jal, w_jalr, w_branch;
  logic              w_is_load, w_is_store, w_is_fence;
  logic [2:0]        w_alu_op, w_wb_sel;

  // Opcode decode: datapath controls that hold while the instruction is in flight.
  always_comb begin
    w_legal    = 1'b1;
    w_alu_a    = CTL_ALU_A_RS1;
    w_alu_b    = CTL_ALU_B_RS2;
    w_alu_op   = CTL_ALU_ZERO;
    w_wb_sel   = CTL_WRITEBACK_ALU;
    w_rf_we    = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_branch   = 1'b0;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_fence = 1'b0;
`ifdef M_MODULE_EN
    w_is_mul   = 1'b0;
`endif
    case (inst_opcode)
      OPC_LOAD: begin
        w_alu_b = CTL_ALU_B_IMM; w_alu_op = CTL_ALU_ADD; w_wb_sel = CTL_WRITEBACK_DATA;
        w_rf_we = 1'b1; w_is_load = 1'b1;
      end
      OPC_STORE: begin
        w_alu_b = CTL_ALU_B_IMM; w_alu_op = CTL_ALU_ADD; w_is_store = 1'b1;
      end
      OPC_OP_IMM: begin
        w_alu_b = CTL_ALU_B_IMM; w_alu_op = CTL_ALU_DEFAULT; w_rf_we = 1'b1;
      end
      OPC_AUIPC: begin
        w_alu_a = CTL_ALU_A_PC; w_alu_b = CTL_ALU_B_IMM; w_alu_op = CTL_ALU_ADD; w_rf_we = 1'b1;
      end
      OPC_OP: begin
        w_rf_we = 1'b1;
`ifdef M_MODULE_EN
        // bit 30 (SUB/SRA) outranks bit 25 (M-extension)
        w_is_mul = ~inst_bit_30 & inst_bit_25;
        w_alu_op = inst_bit_30 ? CTL_ALU_SECONDARY :
                   (w_is_mul ? CTL_ALU_M_EXTENSION : CTL_ALU_DEFAULT);
`else
        w_alu_op = inst_bit_30 ? CTL_ALU_SECONDARY : CTL_ALU_DEFAULT;
`endif
      end
      OPC_LUI: begin
        w_alu_op = CTL_ALU_ZERO; w_wb_sel = CTL_WRITEBACK_IMM; w_rf_we = 1'b1;
      end
      OPC_BRANCH: begin
        w_alu_op = CTL_ALU_BRANCH; w_branch = 1'b1;
      end
      OPC_JALR: begin
        w_alu_b = CTL_ALU_B_IMM; w_alu_op = CTL_ALU_ADD; w_wb_sel = CTL_WRITEBACK_PC4;
        w_rf_we = 1'b1; w_jalr = 1'b1;
      end
      OPC_JAL: begin
        w_alu_a = CTL_ALU_A_PC; w_alu_b = CTL_ALU_B_IMM; w_alu_op = CTL_ALU_ADD;
        w_wb_sel = CTL_WRITEBACK_PC4; w_rf_we = 1'b1; w_jal = 1'b1;
      end
      OPC_MISC_MEM: w_is_fence = 1'b1;
      default:      w_legal = 1'b0;
    endcase
  end

  assign w_expire = (r_wait_cnt == WAIT_W'(WAIT_LIMIT - 1));

  // Next-state and trap-cause selection; a stalled cycle that would hit the limit traps unless ready arrives.
  always_comb begin
    w_next_state = r_state;
    w_next_cause = r_trap_cause;
    w_waiting    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (inst_mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_waiting    = 1'b1;
          w_next_state = w_expire ? S_TRAP : S_FETCH;
          w_next_cause = w_expire ? CAUSE_MEM_TIMEOUT : r_trap_cause;
        end
      end
      S_DECODE: begin
        if (!w_legal) begin
          w_next_state = S_TRAP;
          w_next_cause = CAUSE_ILLEGAL;
        end else begin
          w_next_state = w_is_fence ? S_WRITEBACK : S_EXECUTE;
        end
      end
      S_EXECUTE: begin
`ifdef M_MODULE_EN
        if (w_is_mul && !alu_done) begin
          w_waiting    = 1'b1;
          w_next_state = w_expire ? S_TRAP : S_EXECUTE;
          w_next_cause = w_expire ? CAUSE_M_TIMEOUT : r_trap_cause;
        end else
`endif
        if (w_is_load || w_is_store) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WRITEBACK;
        end
      end
      S_MEM: begin
        if (data_mem_ready) begin
          w_next_state = S_WRITEBACK;
        end else begin
          w_waiting    = 1'b1;
          w_next_state = w_expire ? S_TRAP : S_MEM;
          w_next_cause = w_expire ? CAUSE_MEM_TIMEOUT : r_trap_cause;
        end
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_TRAP:      w_next_state = S_TRAP;
      default:     w_next_state = S_TRAP;
    endcase
  end

  // State, watchdog counter and sticky trap cause.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= {WAIT_W{1'b0}};
      r_trap_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_next_state;
      r_trap_cause <= w_next_cause;
      if (w_next_state != r_state) begin
        r_wait_cnt <= {WAIT_W{1'b0}};
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
    end
  end

  // Moore strobes from state plus opcode; gated by reset_n so they drop without a clock edge.
  always_comb begin
    inst_mem_read_enable  = 1'b0;
    ir_write_enable       = 1'b0;
    pc_write_enable       = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = 1'b0;
    alu_operand_b_select  = 1'b0;
    alu_op_type           = 3'd0;
    jal_enable            = 1'b0;
    jalr_enable           = 1'b0;
    branch_enable         = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    reg_writeback_select  = 3'd0;
    trap                  = 1'b0;
    trap_cause            = 2'd0;
    if (!reset_n) begin
      trap_cause = 2'd0;
    end else begin
      trap_cause = r_trap_cause;
      if (r_state == S_EXECUTE || r_state == S_MEM || r_state == S_WRITEBACK) begin
        alu_operand_a_select = w_alu_a;
        alu_operand_b_select = w_alu_b;
        alu_op_type          = w_alu_op;
      end else begin
        alu_op_type          = 3'd0;
      end
      case (r_state)
        S_FETCH: begin
          inst_mem_read_enable = 1'b1;
          ir_write_enable      = inst_mem_ready;
        end
        S_MEM: begin
          data_mem_read_enable  = w_is_load;
          data_mem_write_enable = w_is_store;
        end
        S_WRITEBACK: begin
          pc_write_enable      = 1'b1;
          regfile_write_enable = w_rf_we;
          jal_enable           = w_jal;
          jalr_enable          = w_jalr;
          branch_enable        = w_branch;
          reg_writeback_select = w_wb_sel;
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control FSM for the RISC-V SiMPLE SV core: next generation of the single-cycle control path. It sequences each RV32I instruction through fetch, decode, execute, memory and writeback states. It stalls on instruction/data memory ready handshakes and on a multi-cycle M-extension unit, and drives the same datapath strobes as single-cycle control. A watchdog traps on memory timeout or illegal opcode.

## Interface
- `WAIT_LIMIT`, 15: maximum consecutive cycles any ready/done input may stay low before trapping; 1..255.
- `WAIT_W`, `$clog2(WAIT_LIMIT+1)`: wait-counter width (derived, not overridden).
- `clock` in 1: the single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `inst_opcode` in 7: opcode field of the instruction register (held by datapath).
- `inst_bit_30` in 1: ALU secondary-op select.
- `inst_bit_25` in 1: M-extension select (ignored without the macro).
- `inst_mem_ready` in 1: instruction memory has returned the word this cycle.
- `data_mem_ready` in 1: data memory access completes this cycle.
- `alu_done` in 1: M-extension result valid (ignored without the macro).
- `inst_mem_read_enable` out 1: request instruction fetch.
- `ir_write_enable` out 1: load instruction register.
- `pc_write_enable` out 1: update PC; exactly one pulse per retired instruction.
- `regfile_write_enable` out 1.
- `alu_operand_a_select`, `alu_operand_b_select` out 1 each: `CTL_ALU_A_*` / `CTL_ALU_B_*` encodings.
- `alu_op_type` out 3: `CTL_ALU_*` encoding.
- `jal_enable`, `jalr_enable`, `branch_enable` out 1 each.
- `data_mem_read_enable`, `data_mem_write_enable` out 1 each.
- `reg_writeback_select` out 3: `CTL_WRITEBACK_*` encoding.
- `trap` out 1: sticky fault flag.
- `trap_cause` out 2: 0 none, 1 illegal opcode, 2 memory timeout, 3 M-unit timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- Outputs are Moore-decoded from the state plus the opcode and bits.
- All outputs are 0 while `reset_n` is low. After reset, the FSM is in FETCH, `trap` = 0, `trap_cause` = 0, and the wait counter = 0.
- FETCH:
  - `inst_mem_read_enable` = 1.
  - On `inst_mem_ready`: pulse `ir_write_enable` and go to DECODE.
- DECODE:
  - Classify the opcode. An unrecognised opcode goes to TRAP with cause 1.
  - MISC_MEM (fence) goes directly to WRITEBACK.
  - All other opcodes go to EXECUTE.
- EXECUTE:
  - ALU selects and `alu_op_type` per opcode, exactly as in the single-cycle mapping.
  - OP with bit 30 uses SECONDARY, otherwise DEFAULT. LUI uses ZERO with writeback IMM.
  - LOAD/STORE go to MEM. Others go to WRITEBACK.
- MEM:
  - Holds the address ALU controls.
  - `data_mem_read_enable` or `data_mem_write_enable` stays high until `data_mem_ready`, then goes to WRITEBACK.
- WRITEBACK:
  - `pc_write_enable` = 1.
  - `regfile_write_enable` = 1 for LOAD, OP_IMM, AUIPC, OP, LUI, JAL, JALR.
  - `jal_enable`, `jalr_enable` and `branch_enable` assert here only.
  - Writeback select per opcode. Then go to FETCH.
- TRAP:
  - All strobes are 0; `trap` = 1.
  - Left only by reset.
- Wait counter:
  - Increments each cycle in FETCH or MEM while ready is low. Clears on state change.
  - Reaching `WAIT_LIMIT` goes to TRAP with cause 2.
- If ready arrives on the same cycle the counter reaches `WAIT_LIMIT`, ready wins.

## Timing
- Zero-wait latency in cycles, FETCH entry to the next FETCH entry:
  - ALU, LUI, AUIPC, JAL, JALR and branch: 4.
  - Fence: 3.
  - Load/store: 5.
- Each low cycle of `inst_mem_ready` or `data_mem_ready` adds one cycle.
- `pc_write_enable` high for exactly 1 cycle per instruction; never in TRAP.
- `reset_n` asserted mid-instruction: outputs drop to 0 asynchronously. On release, execution restarts at FETCH with no pending strobe.

## Configuration
- `M_MODULE_EN` defined:
  - OP with `inst_bit_30` = 0 and `inst_bit_25` = 1 drives `CTL_ALU_M_EXTENSION`.
  - EXECUTE holds until `alu_done`, counted by the watchdog; expiry gives cause 3.
  - Bit 30 has priority over bit 25.
- `M_MODULE_EN` undefined:
  - `inst_bit_25` and `alu_done` are ignored; EXECUTE is always 1 cycle.
  - Cause 3 is never produced.

## Test plan
- ADDI, zero-wait memory → `pc_write_enable` pulses on cycle 4 after reset release, with `regfile_write_enable` = 1 and `alu_op_type` = DEFAULT in the same cycle.
- LW with `data_mem_ready` low for 3 cycles → `data_mem_read_enable` high 4 cycles, instruction latency 8, writeback select DATA.
- Opcode 7'b1111111 → `trap` = 1 and `trap_cause` = 1 on the cycle after DECODE; no further `pc_write_enable` until `reset_n` pulses low.
- `inst_mem_ready` held low with `WAIT_LIMIT` = 4 → TRAP with `trap_cause` = 2 after 4 FETCH cycles. A variant raising ready on the 4th cycle → no trap.
- `reset_n` dropped during MEM of an SW → `data_mem_write_enable` falls without a clock edge; after release, first cycle has `inst_mem_read_enable` = 1.
- With `M_MODULE_EN`: MUL with `alu_done` after 5 cycles → `alu_op_type` = M_EXTENSION throughout, latency 8. Without the macro: same stimulus → latency 4, `alu_op_type` = DEFAULT.
